if_fetch_unit: RTL

- Instruction-fetch stage that drives pc/instruction pairs into the decode stage.
- Consumes the decoder's branch redirect, the reverse direction of the decode interface.
- Keeps a PC register and issues in-order requests to instruction memory.
- Buffers responses in a small queue and discards responses that a redirect has made stale.

---
 rtl/if_fetch_unit_pkg.sv | 7 +
 rtl/if_fetch_unit_fetch_queue.sv | 60 ++++++
 rtl/if_fetch_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: constants and fetch FSM state shared by the fetch and decode stages.
package if_fetch_unit_pkg;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN, ERR} fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// fetch_queue: in-order fetch buffer; entries are allocated at request time and filled by responses.
module fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc,
    input  logic [31:0]              alloc_pc,
    input  logic                     fill,
    input  logic [31:0]              fill_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head_filled,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_inst,
    output logic [$clog2(QDEPTH):0]  occupancy,
    output logic [$clog2(QDEPTH):0]  unfilled
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    logic [AW:0] rd_ptr, fill_ptr, wr_ptr;
    logic [31:0] pc_mem [QDEPTH];
    logic [31:0] inst_mem [QDEPTH];
    // entries in [rd_ptr, fill_ptr) are filled, [fill_ptr, wr_ptr) await their response
    assign occupancy   = wr_ptr - rd_ptr;
    assign unfilled    = wr_ptr - fill_ptr;
    assign head_filled = fill_ptr != rd_ptr;
    assign head_pc     = pc_mem[rd_ptr[AW-1:0]];
    assign head_inst   = inst_mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            fill_ptr <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= NOP_INST;
            end
        end else if (flush) begin
            rd_ptr   <= '0;
            fill_ptr <= '0;
            wr_ptr   <= '0;
        end else begin
            if (alloc) begin
                pc_mem[wr_ptr[AW-1:0]] <= alloc_pc;
                wr_ptr <= wr_ptr + ONE;
            end
            if (fill) begin
                inst_mem[fill_ptr[AW-1:0]] <= fill_data;
                fill_ptr <= fill_ptr + ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + ONE;
        end
    end
    assert property (@(posedge clk) disable iff (rst) !(alloc && occupancy == (AW+1)'(QDEPTH)));
    assert property (@(posedge clk) disable iff (rst) !(fill && unfilled == '0));
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage feeding decode, with redirect and stale-response dropping.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky error state (fetch_err).
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid,
    input  logic        inst_ready
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_err
`endif
);
    localparam int AW = $clog2(QDEPTH);
    fetch_state_e state, state_nxt;
    logic [31:0] fetch_pc, redirect_pc, head_pc, head_inst;
    logic [AW:0] drop_cnt, drop_nxt, occupancy, unfilled;
    logic head_filled, handshake, fill, pop, misaligned;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned  = branch_taken && branch_addr[1:0] != 2'b00;
    assign redirect_pc = branch_addr;
    assign fetch_err   = state == ERR;
`else
    assign misaligned  = 1'b0;
    assign redirect_pc = branch_addr & ~32'h3;
`endif
    // stale responses still owed by memory count against the same QDEPTH budget
    assign imem_req_valid = (state == RUN || state == DRAIN) && !branch_taken &&
        ({1'b0, occupancy} + {1'b0, drop_cnt} < (AW+2)'(QDEPTH));
    assign imem_addr  = fetch_pc;
    assign handshake  = imem_req_valid && imem_req_ready;
    assign fill       = imem_rsp_valid && drop_cnt == '0 && !branch_taken && state != ERR;
    assign inst_valid = head_filled && state != ERR;
    assign pop        = inst_valid && inst_ready;
    assign pc_o       = head_pc;
    assign inst_o     = inst_valid ? head_inst : NOP_INST;
    assign drop_nxt   = branch_taken ? drop_cnt + unfilled - (AW+1)'(imem_rsp_valid)
                                     : drop_cnt - (AW+1)'(imem_rsp_valid && drop_cnt != '0);
    always_comb begin
        state_nxt = (misaligned || state == ERR) ? ERR :
                    (state == BOOT) ? RUN :
                    (branch_taken && drop_nxt != '0) ? DRAIN :
                    (drop_nxt == '0) ? RUN : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            fetch_pc <= branch_taken ? redirect_pc : handshake ? fetch_pc + 32'd4 : fetch_pc;
        end
    end
    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .alloc       (handshake),
        .alloc_pc    (fetch_pc),
        .fill        (fill),
        .fill_data   (imem_rsp_data),
        .pop         (pop),
        .flush       (branch_taken),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_inst   (head_inst),
        .occupancy   (occupancy),
        .unfilled    (unfilled)
    );
endmodule
